// File: rtl/nv_pipe_pkg.sv
// Shared helpers for the nv_pipe retiming bank.
// Occupancy width sizing used by the top and by users of the bank.
package nv_pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;

  function automatic int clog2p1(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/nv_pipe_stage.sv
// One flow-controlled vld/pd register of the retiming bank.
// Data reset only when NV_PIPE_RESET_DATA_EN is defined.
module nv_pipe_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] pd_i,
  input  logic             rdy_dn_i,
  output logic             rdy_o,
  output logic             vld_o,
  output logic [WIDTH-1:0] pd_o
);

  logic             vld_q;
  logic [WIDTH-1:0] pd_q;

  assign rdy_o = ~vld_q | rdy_dn_i;
  assign vld_o = vld_q;
  assign pd_o  = pd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
    end else if (rdy_o) begin
      vld_q <= vld_i;
    end
  end

`ifdef NV_PIPE_RESET_DATA_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pd_q <= RESET_VAL;
    end else if (rdy_o & vld_i) begin
      pd_q <= pd_i;
    end
  end
`else
  // Payload only moves with a valid beat, so no reset is needed.
  logic unused_rst_val;
  assign unused_rst_val = ^RESET_VAL;

  always_ff @(posedge clk_i) begin
    if (rdy_o & vld_i) begin
      pd_q <= pd_i;
    end
  end
`endif

endmodule

// File: rtl/nv_pipe_retime_bank.sv
// DEPTH-stage valid/ready retiming bank with bubble collapse.
// Optional payload reset: NV_PIPE_RESET_DATA_EN.
module nv_pipe_retime_bank
  import nv_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              OCC_W     = clog2p1(DEPTH)
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             in_pvld,
  output logic             in_prdy,
  input  logic [WIDTH-1:0] in_pd,
  output logic             out_pvld,
  input  logic             out_prdy,
  output logic [WIDTH-1:0] out_pd,
  output logic [OCC_W-1:0] occupancy
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("nv_pipe_retime_bank: DEPTH must be >= 1");
  end

  logic             vld [DEPTH+1];
  logic [WIDTH-1:0] pd  [DEPTH+1];
  logic             rdy [DEPTH+1];

  assign vld[0]     = in_pvld;
  assign pd[0]      = in_pd;
  assign rdy[DEPTH] = out_prdy;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    nv_pipe_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clk_i   (nvdla_core_clk),
      .rst_i   (nvdla_core_rst),
      .vld_i   (vld[g]),
      .pd_i    (pd[g]),
      .rdy_dn_i(rdy[g+1]),
      .rdy_o   (rdy[g]),
      .vld_o   (vld[g+1]),
      .pd_o    (pd[g+1])
    );
  end

  assign in_prdy  = rdy[0] & ~nvdla_core_rst;
  assign out_pvld = vld[DEPTH];
  assign out_pd   = pd[DEPTH];

  logic             in_xfer;
  logic             out_xfer;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  assign in_xfer  = in_pvld & in_prdy;
  assign out_xfer = out_pvld & out_prdy;

  always_comb begin
    occ_d = occ_q;
    unique case ({in_xfer, out_xfer})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule
